// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the native valid/ready memory bus.
// Master 0 (core) and master 1 (e.g. DMA) share one slave path. A watchdog
// forces completion of a granted transfer that waits too long for s_ready.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT  = 1024,
    parameter logic [31:0] TO_RDATA = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    input  logic        err_clr,
    output logic        timeout_err,
    output logic [31:0] timeout_addr
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state, state_nx;
    logic [1:0]     grant_nx;
    logic           ptr, ptr_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           done_ok, done_to;
    logic           g_valid;
    logic [31:0]    g_addr, g_wdata;
    logic [3:0]     g_wstrb;
    logic [31:0]    fin_rdata;

    // Request of the current owner; all zero while idle (grant == 0).
    always_comb begin
        g_valid = 1'b0;
        g_addr  = '0;
        g_wdata = '0;
        g_wstrb = '0;
        if (grant[1]) begin
            g_valid = m1_valid;
            g_addr  = m1_addr;
            g_wdata = m1_wdata;
            g_wstrb = m1_wstrb;
        end else if (grant[0]) begin
            g_valid = m0_valid;
            g_addr  = m0_addr;
            g_wdata = m0_wdata;
            g_wstrb = m0_wstrb;
        end
    end

    // Next-state logic: arbitration in IDLE, completion/timeout/abort in BUSY.
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        done_ok  = 1'b0;
        done_to  = 1'b0;
        unique case (state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    if (m0_valid && m1_valid) begin
                        grant_nx = ptr ? 2'b10 : 2'b01;
                    end else begin
                        grant_nx = m1_valid ? 2'b10 : 2'b01;
                    end
                    cnt_nx   = '0;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (!g_valid) begin
                    state_nx = IDLE;
                    grant_nx = 2'b00;
                    ptr_nx   = ~grant[1];
                end else if (s_ready) begin
                    done_ok  = 1'b1;
                    state_nx = IDLE;
                    grant_nx = 2'b00;
                    ptr_nx   = ~grant[1];
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    done_to  = 1'b1;
                    state_nx = IDLE;
                    grant_nx = 2'b00;
                    ptr_nx   = ~grant[1];
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Bus-facing outputs; reset suppresses any completion still in flight.
    always_comb begin
        fin_rdata = done_to ? TO_RDATA : s_rdata;
        s_valid   = (state == BUSY) && g_valid && !done_to && !rst;
        s_addr    = g_addr;
        s_wdata   = g_wdata;
        s_wstrb   = g_wstrb;
        m0_ready  = grant[0] && (done_ok || done_to) && !rst;
        m1_ready  = grant[1] && (done_ok || done_to) && !rst;
        m0_rdata  = m0_ready ? fin_rdata : '0;
        m1_rdata  = m1_ready ? fin_rdata : '0;
    end

    // State, grant, pointer, watchdog counter and sticky error capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            grant        <= 2'b00;
            ptr          <= 1'b0;
            cnt          <= '0;
            timeout_err  <= 1'b0;
            timeout_addr <= '0;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
            if (done_to) begin
                timeout_err  <= 1'b1;
                timeout_addr <= g_addr;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus a
// randomized run against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

    localparam int unsigned TO  = 16;
    localparam logic [31:0] TOR = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_valid, m0_ready, m1_valid, m1_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  grant;
    logic        err_clr, timeout_err;
    logic [31:0] timeout_addr;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.TIMEOUT(TO), .TO_RDATA(TOR)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .grant(grant), .err_clr(err_clr), .timeout_err(timeout_err),
        .timeout_addr(timeout_addr)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        m0_valid = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready = 0; s_rdata = '0; err_clr = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({grant, s_valid, m0_ready, m1_ready, timeout_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=000000", {grant, s_valid, m0_ready, m1_ready, timeout_err});
        end
        checks++;
        if ({s_addr, s_wdata, s_wstrb, m0_rdata, m1_rdata, timeout_addr} !== '0) begin
            failures++;
            $display("FAIL reset_data got addr=%h wdata=%h wstrb=%h r0=%h r1=%h taddr=%h exp all 0",
                     s_addr, s_wdata, s_wstrb, m0_rdata, m1_rdata, timeout_addr);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        @(negedge clk); m0_valid = 1; m0_addr = 32'h0000_0100; m0_wstrb = 4'h0;
        #1; checks++;
        if (grant !== 2'b00) begin failures++; $display("FAIL sr_arb_latency grant=%b exp=00", grant); end
        @(negedge clk); #1; checks++;
        if ({grant, s_valid, m0_ready} !== 4'b0110 || s_addr !== 32'h100 || s_wstrb !== 4'h0) begin
            failures++;
            $display("FAIL sr_busy1 grant=%b sv=%b rdy=%b addr=%h exp 01/1/0/00000100", grant, s_valid, m0_ready, s_addr);
        end
        @(negedge clk); #1; checks++;
        if ({grant, m0_ready} !== 3'b010) begin failures++; $display("FAIL sr_busy2 grant=%b rdy=%b exp 01/0", grant, m0_ready); end
        @(negedge clk); s_ready = 1; s_rdata = 32'h1234_5678; #1; checks++;
        if ({m0_ready, m1_ready} !== 2'b10 || m0_rdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL sr_done rdy0=%b rdy1=%b rdata=%h exp 1/0/12345678", m0_ready, m1_ready, m0_rdata);
        end
        @(negedge clk); s_ready = 0; m0_valid = 0; #1; checks++;
        if ({grant, m0_ready} !== 3'b000 || m0_rdata !== '0) begin
            failures++;
            $display("FAIL sr_after grant=%b rdy=%b rdata=%h exp 00/0/0", grant, m0_ready, m0_rdata);
        end
    endtask

    task automatic test_write_holdoff();
        do_reset();
        @(negedge clk); m1_valid = 1; m1_addr = 32'h9000_0000; m1_wdata = 32'h41; m1_wstrb = 4'hF;
        @(negedge clk); m0_valid = 1; m0_addr = 32'h0000_0200; m0_wstrb = 4'h0; #1; checks++;
        if ({grant, s_valid, m0_ready} !== 4'b1010 || s_addr !== 32'h9000_0000 || s_wdata !== 32'h41 || s_wstrb !== 4'hF) begin
            failures++;
            $display("FAIL wr_bus grant=%b sv=%b r0=%b addr=%h wd=%h ws=%h exp 10/1/0/90000000/41/f",
                     grant, s_valid, m0_ready, s_addr, s_wdata, s_wstrb);
        end
        @(negedge clk); s_ready = 1; s_rdata = 32'hDEAD_0001; #1; checks++;
        if ({m1_ready, m0_ready} !== 2'b10 || m1_rdata !== 32'hDEAD_0001 || m0_rdata !== '0) begin
            failures++;
            $display("FAIL wr_done r1=%b r0=%b rd1=%h rd0=%h exp 1/0/dead0001/0", m1_ready, m0_ready, m1_rdata, m0_rdata);
        end
        @(negedge clk); s_ready = 0; m1_valid = 0; #1; checks++;
        if (grant !== 2'b00) begin failures++; $display("FAIL wr_idle grant=%b exp=00", grant); end
        @(negedge clk); #1; checks++;
        if ({grant, s_valid} !== 3'b011 || s_addr !== 32'h200) begin
            failures++;
            $display("FAIL wr_m0_next grant=%b sv=%b addr=%h exp 01/1/00000200", grant, s_valid, s_addr);
        end
        @(negedge clk); s_ready = 1; #1;
        @(negedge clk); s_ready = 0; m0_valid = 0;
    endtask

    task automatic test_timeout();
        do_reset();
        @(negedge clk); m0_valid = 1; m0_addr = 32'h5000_0004; m0_wstrb = 4'h0;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk); #1; checks++;
            if (k < TO) begin
                if ({s_valid, m0_ready} !== 2'b10) begin
                    failures++; $display("FAIL to_wait cyc=%0d sv=%b rdy=%b exp 1/0", k, s_valid, m0_ready);
                end
            end else if ({s_valid, m0_ready} !== 2'b01 || m0_rdata !== TOR) begin
                failures++; $display("FAIL to_fire sv=%b rdy=%b rdata=%h exp 0/1/ffffffff", s_valid, m0_ready, m0_rdata);
            end
        end
        @(negedge clk); m0_valid = 0; #1; checks++;
        if ({grant, timeout_err} !== 3'b001 || timeout_addr !== 32'h5000_0004) begin
            failures++; $display("FAIL to_err grant=%b err=%b taddr=%h exp 00/1/50000004", grant, timeout_err, timeout_addr);
        end
        @(negedge clk); err_clr = 1;
        @(negedge clk); err_clr = 0; #1; checks++;
        if (timeout_err !== 1'b0) begin failures++; $display("FAIL to_clear err=%b exp=0", timeout_err); end
        // ready arriving on the very last watchdog cycle is a normal completion
        @(negedge clk); m0_valid = 1; m0_addr = 32'h5000_0008;
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk); s_ready = (k == TO); s_rdata = 32'hA5A5_0001; #1;
        end
        checks++;
        if ({s_valid, m0_ready} !== 2'b11 || m0_rdata !== 32'hA5A5_0001) begin
            failures++; $display("FAIL to_edge_done sv=%b rdy=%b rdata=%h exp 1/1/a5a50001", s_valid, m0_ready, m0_rdata);
        end
        @(negedge clk); s_ready = 0; m0_valid = 0; #1; checks++;
        if (timeout_err !== 1'b0 || timeout_addr !== 32'h5000_0004) begin
            failures++; $display("FAIL to_edge_err err=%b taddr=%h exp 0/50000004", timeout_err, timeout_addr);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        // complete one master-0 transfer so the pointer favours master 1
        @(negedge clk); m0_valid = 1; m0_addr = 32'h10;
        @(negedge clk);
        @(negedge clk); s_ready = 1;
        @(negedge clk); s_ready = 0; m0_valid = 0;
        @(negedge clk); m0_valid = 1; m0_addr = 32'h20;
        @(negedge clk); #1; checks++;
        if (grant !== 2'b01) begin failures++; $display("FAIL rm_grant grant=%b exp=01", grant); end
        @(negedge clk); rst = 1; s_ready = 1; #1; checks++;
        if ({m0_ready, m1_ready} !== 2'b00) begin
            failures++; $display("FAIL rm_noready r0=%b r1=%b exp 0/0", m0_ready, m1_ready);
        end
        @(negedge clk); rst = 0; s_ready = 0; m1_valid = 1; m1_addr = 32'h30; #1; checks++;
        if ({grant, m0_ready, m1_ready, s_valid} !== 5'b0) begin
            failures++; $display("FAIL rm_idle grant=%b r0=%b r1=%b sv=%b exp 00/0/0/0", grant, m0_ready, m1_ready, s_valid);
        end
        @(negedge clk); #1; checks++;
        if (grant !== 2'b01) begin failures++; $display("FAIL rm_pointer grant=%b exp=01", grant); end
    endtask

    task automatic test_random();
        logic        pend [2];
        logic [31:0] a [2];
        logic [31:0] w [2];
        logic [3:0]  st [2];
        int          owner, last, bc, rdy_at;
        logic        merr, sr, tmo, fin, ev;
        logic [31:0] maddr, srd, ea, ew, er0, er1;
        logic [3:0]  es;
        logic [1:0]  eg;
        do_reset();
        owner = -1; last = 1; bc = 0; rdy_at = 0; merr = 0; maddr = '0;
        for (int i = 0; i < 2; i++) begin pend[i] = 0; a[i] = '0; w[i] = '0; st[i] = '0; end
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1; a[i] = $urandom; w[i] = $urandom; st[i] = 4'($urandom_range(0, 15));
                end
            end
            m0_valid = pend[0]; m0_addr = a[0]; m0_wdata = w[0]; m0_wstrb = st[0];
            m1_valid = pend[1]; m1_addr = a[1]; m1_wdata = w[1]; m1_wstrb = st[1];
            err_clr = ($urandom_range(0, 15) == 0);
            srd = $urandom;
            if (owner >= 0) begin bc++; sr = (bc == rdy_at); end
            else sr = ($urandom_range(0, 3) == 0);
            s_ready = sr; s_rdata = srd;
            tmo = (owner >= 0) && !sr && (bc == TO);
            fin = (owner >= 0) && (sr || tmo);
            ev  = (owner >= 0) && !tmo;
            eg  = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
            ea  = (owner == 0) ? a[0]  : (owner == 1) ? a[1]  : '0;
            ew  = (owner == 0) ? w[0]  : (owner == 1) ? w[1]  : '0;
            es  = (owner == 0) ? st[0] : (owner == 1) ? st[1] : '0;
            er0 = (fin && owner == 0) ? (tmo ? TOR : srd) : '0;
            er1 = (fin && owner == 1) ? (tmo ? TOR : srd) : '0;
            #1;
            checks++;
            if ({grant, s_valid, m0_ready, m1_ready} !== {eg, ev, fin && owner == 0, fin && owner == 1}) begin
                failures++;
                $display("FAIL rnd_ctl n=%0d got g=%b sv=%b r0=%b r1=%b exp g=%b sv=%b r0=%b r1=%b", n,
                         grant, s_valid, m0_ready, m1_ready, eg, ev, fin && owner == 0, fin && owner == 1);
            end
            checks++;
            if ({s_addr, s_wdata, s_wstrb} !== {ea, ew, es}) begin
                failures++;
                $display("FAIL rnd_sbus n=%0d got %h/%h/%h exp %h/%h/%h", n, s_addr, s_wdata, s_wstrb, ea, ew, es);
            end
            checks++;
            if ({m0_rdata, m1_rdata} !== {er0, er1}) begin
                failures++;
                $display("FAIL rnd_rdata n=%0d got %h/%h exp %h/%h", n, m0_rdata, m1_rdata, er0, er1);
            end
            checks++;
            if ({timeout_err, timeout_addr} !== {merr, maddr}) begin
                failures++;
                $display("FAIL rnd_err n=%0d got %b/%h exp %b/%h", n, timeout_err, timeout_addr, merr, maddr);
            end
            if (tmo) begin merr = 1; maddr = ea; end
            else if (err_clr) merr = 0;
            if (owner < 0) begin
                if (pend[0] || pend[1]) begin
                    owner = (pend[0] && pend[1]) ? ((last == 0) ? 1 : 0) : (pend[1] ? 1 : 0);
                    bc = 0;
                    case ($urandom_range(0, 9))
                        6: rdy_at = TO - 1;
                        7: rdy_at = TO;
                        8, 9: rdy_at = TO + 5;
                        default: rdy_at = 1 + $urandom_range(0, 3);
                    endcase
                end
            end else if (fin) begin
                pend[owner] = 0; last = owner; owner = -1;
            end
        end
    endtask

    initial begin
        rst = 1;
        test_reset();
        test_single_read();
        test_write_holdoff();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
